// File: rtl/fpga.sv
// Shared serial-bus transmitter: 16 source nodes, fixed-priority arbitration,
// 78-bit framed packet shifted out MSB first on a registered bus line.
module fpga (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  CRC1,  CRC2,  CRC3,  CRC4,  CRC5,  CRC6,  CRC7,  CRC8,
    input  logic [3:0]  CRC9,  CRC10, CRC11, CRC12, CRC13, CRC14, CRC15, CRC16,
    input  logic [63:0] Data1,  Data2,  Data3,  Data4,  Data5,  Data6,  Data7,  Data8,
    input  logic [63:0] Data9,  Data10, Data11, Data12, Data13, Data14, Data15, Data16,
    input  logic [3:0]  receiverAddr1,  receiverAddr2,  receiverAddr3,  receiverAddr4,
    input  logic [3:0]  receiverAddr5,  receiverAddr6,  receiverAddr7,  receiverAddr8,
    input  logic [3:0]  receiverAddr9,  receiverAddr10, receiverAddr11, receiverAddr12,
    input  logic [3:0]  receiverAddr13, receiverAddr14, receiverAddr15, receiverAddr16,
    input  logic [15:0] mod,
    output logic        bus_show
);

    typedef enum logic {IDLE, SEND} state_t;

    // Index of the last frame bit (stop bit); frame is 78 bits long.
    localparam logic [6:0] LAST_IDX = 7'd77;

    // Node fields packed so that element 0 is node 1.
    logic [15:0][63:0] data_arr;
    logic [15:0][3:0]  addr_arr;
    logic [15:0][3:0]  crc_arr;

    assign data_arr = {Data16, Data15, Data14, Data13, Data12, Data11, Data10, Data9,
                       Data8,  Data7,  Data6,  Data5,  Data4,  Data3,  Data2,  Data1};
    assign addr_arr = {receiverAddr16, receiverAddr15, receiverAddr14, receiverAddr13,
                       receiverAddr12, receiverAddr11, receiverAddr10, receiverAddr9,
                       receiverAddr8,  receiverAddr7,  receiverAddr6,  receiverAddr5,
                       receiverAddr4,  receiverAddr3,  receiverAddr2,  receiverAddr1};
    assign crc_arr  = {CRC16, CRC15, CRC14, CRC13, CRC12, CRC11, CRC10, CRC9,
                       CRC8,  CRC7,  CRC6,  CRC5,  CRC4,  CRC3,  CRC2,  CRC1};

    state_t      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [77:0] shift_q, shift_d;
    logic        bus_show_q, bus_show_d;

    logic [3:0]  sel_idx;
    logic [77:0] frame_load;

    // Fixed-priority arbiter: lowest set request bit wins (scan high to low).
    always_comb begin
        sel_idx = 4'h0;
        for (int i = 15; i >= 0; i--) begin
            if (mod[i]) begin
                sel_idx = i[3:0];
            end
        end
    end

    // Whole frame of the winning node; sender address equals the node index.
    assign frame_load = {1'b1, sel_idx, addr_arr[sel_idx], data_arr[sel_idx],
                         crc_arr[sel_idx], 1'b1};

    // Next-state logic: latch on request in IDLE, shift one bit per clock in SEND.
    // The start bit goes straight to the output; the remaining 77 bits sit
    // left-aligned in the shift register.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        bus_show_d = bus_show_q;
        case (state_q)
            IDLE: begin
                bus_show_d = 1'b0;
                cnt_d      = 7'd0;
                if (mod != 16'h0000) begin
                    state_d    = SEND;
                    shift_d    = {frame_load[76:0], 1'b0};
                    bus_show_d = 1'b1;
                end
            end
            SEND: begin
                if (cnt_q == LAST_IDX) begin
                    // Stop bit has been shown for a full cycle: one forced idle cycle.
                    state_d    = IDLE;
                    bus_show_d = 1'b0;
                    cnt_d      = 7'd0;
                    shift_d    = '0;
                end else begin
                    bus_show_d = shift_q[77];
                    shift_d    = {shift_q[76:0], 1'b0};
                    cnt_d      = cnt_q + 7'd1;
                end
            end
            default: begin
                state_d    = IDLE;
                bus_show_d = 1'b0;
                cnt_d      = 7'd0;
                shift_d    = '0;
            end
        endcase
    end

    // State register with synchronous reset; reset aborts any frame in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 7'd0;
            shift_q    <= '0;
            bus_show_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            bus_show_q <= bus_show_d;
        end
    end

    assign bus_show = bus_show_q;

endmodule

// File: tb/tb_fpga.sv
// Testbench for fpga: table-driven frame checks, hand-written corner sequences,
// and randomized traffic checked cycle by cycle against a bit-queue model.
module tb_fpga;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] mod   = 16'h0000;
    logic [63:0] data  [16];
    logic [3:0]  raddr [16];
    logic [3:0]  crc   [16];
    logic        bus_show;

    always #5 clock = ~clock;

    fpga dut (
        .clock(clock), .reset(reset),
        .CRC1(crc[0]),   .CRC2(crc[1]),   .CRC3(crc[2]),   .CRC4(crc[3]),
        .CRC5(crc[4]),   .CRC6(crc[5]),   .CRC7(crc[6]),   .CRC8(crc[7]),
        .CRC9(crc[8]),   .CRC10(crc[9]),  .CRC11(crc[10]), .CRC12(crc[11]),
        .CRC13(crc[12]), .CRC14(crc[13]), .CRC15(crc[14]), .CRC16(crc[15]),
        .Data1(data[0]),   .Data2(data[1]),   .Data3(data[2]),   .Data4(data[3]),
        .Data5(data[4]),   .Data6(data[5]),   .Data7(data[6]),   .Data8(data[7]),
        .Data9(data[8]),   .Data10(data[9]),  .Data11(data[10]), .Data12(data[11]),
        .Data13(data[12]), .Data14(data[13]), .Data15(data[14]), .Data16(data[15]),
        .receiverAddr1(raddr[0]),   .receiverAddr2(raddr[1]),
        .receiverAddr3(raddr[2]),   .receiverAddr4(raddr[3]),
        .receiverAddr5(raddr[4]),   .receiverAddr6(raddr[5]),
        .receiverAddr7(raddr[6]),   .receiverAddr8(raddr[7]),
        .receiverAddr9(raddr[8]),   .receiverAddr10(raddr[9]),
        .receiverAddr11(raddr[10]), .receiverAddr12(raddr[11]),
        .receiverAddr13(raddr[12]), .receiverAddr14(raddr[13]),
        .receiverAddr15(raddr[14]), .receiverAddr16(raddr[15]),
        .mod(mod),
        .bus_show(bus_show)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the bits still owed on the bus, oldest first.
    bit   model_q[$];
    logic exp_bit = 1'b0;

    typedef struct {
        logic [15:0] m;
        int          node;
        logic [63:0] d;
        logic [3:0]  ra;
        logic [3:0]  c;
        logic [3:0]  snd;
    } vec_t;

    vec_t vt[5];

    function automatic logic [77:0] make_frame(input logic [3:0] s, input logic [3:0] ra,
                                               input logic [63:0] d, input logic [3:0] c);
        return {1'b1, s, ra, d, c, 1'b1};
    endfunction

    task automatic check(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: bus_show=%b required %b at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_frame(input string nm, input logic [77:0] act, input logic [77:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: frame=%h required %h", nm, act, exp);
        end else begin
            $display("frame %s ok: %h", nm, act);
        end
    endtask

    // Model step at a rising edge: reset flushes, otherwise drain the queue,
    // otherwise a request in an empty queue enqueues a whole frame plus one gap bit.
    task automatic model_edge();
        int w;
        if (reset) begin
            model_q.delete();
            exp_bit = 1'b0;
        end else if (model_q.size() > 0) begin
            exp_bit = model_q.pop_front();
        end else if (mod == 16'h0000) begin
            exp_bit = 1'b0;
        end else begin
            w = 0;
            while (!mod[w]) w++;
            exp_bit = 1'b1;
            for (int b = 3; b >= 0; b--)  model_q.push_back(w[b]);
            for (int b = 3; b >= 0; b--)  model_q.push_back(raddr[w][b]);
            for (int b = 63; b >= 0; b--) model_q.push_back(data[w][b]);
            for (int b = 3; b >= 0; b--)  model_q.push_back(crc[w][b]);
            model_q.push_back(1'b1);
            model_q.push_back(1'b0);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        check("model", bus_show, exp_bit);
    endtask

    task automatic grab(input int n, output logic [77:0] f);
        f = '0;
        for (int i = 0; i < n; i++) begin
            tick();
            f = {f[76:0], bus_show};
        end
    endtask

    task automatic go_idle();
        mod = 16'h0000;
        tick();
        tick();
    endtask

    logic [77:0] f;
    int          r;

    initial begin
        for (int i = 0; i < 16; i++) begin
            data[i]  = {$urandom, $urandom};
            raddr[i] = 4'($urandom);
            crc[i]   = 4'($urandom);
        end

        vt[0] = '{m: 16'h0001, node: 0,  d: 64'h1,                 ra: 4'h1, c: 4'h1, snd: 4'h0};
        vt[1] = '{m: 16'h0002, node: 1,  d: 64'h0,                 ra: 4'h2, c: 4'h1, snd: 4'h1};
        vt[2] = '{m: 16'h0003, node: 0,  d: 64'hDEADBEEF_01234567, ra: 4'h9, c: 4'hC, snd: 4'h0};
        vt[3] = '{m: 16'h8000, node: 15, d: 64'hF0F0_A5A5_0FF0_1234, ra: 4'hA, c: 4'h5, snd: 4'hF};
        vt[4] = '{m: 16'h00A0, node: 5,  d: 64'h8000_0000_0000_0001, ra: 4'h6, c: 4'h3, snd: 4'h5};

        // Reset held 3 cycles with no request, then released.
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_low", bus_show, 1'b0);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_reset_low", bus_show, 1'b0);
        end

        // Table of single frames.
        for (int v = 0; v < 5; v++) begin
            go_idle();
            data[vt[v].node]  = vt[v].d;
            raddr[vt[v].node] = vt[v].ra;
            crc[vt[v].node]   = vt[v].c;
            mod = vt[v].m;
            grab(78, f);
            check_frame($sformatf("vec%0d", v), f, make_frame(vt[v].snd, vt[v].ra, vt[v].d, vt[v].c));
            mod = 16'h0000;
            tick();
            check($sformatf("vec%0d_gap", v), bus_show, 1'b0);
        end

        // Request held: gap of exactly one cycle, then an identical repeat frame.
        go_idle();
        data[0] = 64'h1; raddr[0] = 4'h1; crc[0] = 4'h1;
        mod = 16'h0001;
        grab(78, f);
        check_frame("held_first", f, make_frame(4'h0, 4'h1, 64'h1, 4'h1));
        tick();
        check("held_gap", bus_show, 1'b0);
        grab(78, f);
        check_frame("held_repeat", f, make_frame(4'h0, 4'h1, 64'h1, 4'h1));

        // Request and node-1 fields change mid-frame: current frame unchanged.
        go_idle();
        data[0] = 64'h1; raddr[0] = 4'h1; crc[0] = 4'h1;
        mod = 16'h0001;
        f = '0;
        for (int i = 0; i < 78; i++) begin
            tick();
            f = {f[76:0], bus_show};
            if (i == 20) begin
                mod      = 16'h0002;
                data[0]  = 64'hFFFF_FFFF_FFFF_FFFF;
                raddr[0] = 4'hE;
                data[1]  = 64'h0; raddr[1] = 4'h2; crc[1] = 4'h1;
            end
        end
        check_frame("switch_cur", f, make_frame(4'h0, 4'h1, 64'h1, 4'h1));
        tick();
        check("switch_gap", bus_show, 1'b0);
        grab(78, f);
        check_frame("switch_next", f, make_frame(4'h1, 4'h2, 64'h0, 4'h1));

        // Request dropped mid-frame: frame completes, then bus stays low.
        go_idle();
        data[3] = 64'h0123_4567_89AB_CDEF; raddr[3] = 4'h7; crc[3] = 4'hB;
        mod = 16'h0008;
        f = '0;
        for (int i = 0; i < 78; i++) begin
            tick();
            f = {f[76:0], bus_show};
            if (i == 10) mod = 16'h0000;
        end
        check_frame("drop_req", f, make_frame(4'h3, 4'h7, 64'h0123_4567_89AB_CDEF, 4'hB));
        for (int i = 0; i < 5; i++) begin
            tick();
            check("drop_idle", bus_show, 1'b0);
        end

        // Reset at bit index 30: abort, then fresh frame with newly latched fields.
        data[4] = 64'hAAAA_AAAA_AAAA_AAAA; raddr[4] = 4'h3; crc[4] = 4'h9;
        mod = 16'h0010;
        for (int i = 0; i <= 30; i++) tick();
        reset = 1'b1;
        data[4] = 64'h1357_9BDF_2468_ACE0; raddr[4] = 4'hC; crc[4] = 4'h6;
        tick();
        check("rst_abort", bus_show, 1'b0);
        reset = 1'b0;
        grab(78, f);
        check_frame("rst_fresh", f, make_frame(4'h4, 4'hC, 64'h1357_9BDF_2468_ACE0, 4'h6));
        go_idle();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                r = $urandom_range(0, 3);
                if (r == 0)      mod = 16'h0000;
                else if (r == 1) mod = 16'h1 << $urandom_range(0, 15);
                else if (r == 2) mod = 16'($urandom);
            end
            if ($urandom_range(0, 3) == 0) begin
                r = $urandom_range(0, 15);
                data[r]  = {$urandom, $urandom};
                raddr[r] = 4'($urandom);
                crc[r]   = 4'($urandom);
            end
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
